// File: rtl/collision_pkg.sv
// Shared types and constants for the brick collision scheduler and other sprite overlap logic.
package collision_pkg;

    localparam int COORD_W           = 12;
    localparam int DEF_BRICK_WIDTH   = 32;
    localparam int DEF_BRICK_HEIGHT  = 32;
    localparam int DEF_TANK_WIDTH    = 32;
    localparam int DEF_TANK_HEIGHT   = 32;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } state_e;

    // One spare bit of headroom so position + size never wraps near 2047.
    function automatic coord_t to_coord(input logic [10:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/box_overlap.sv
// Combinational inclusive axis-aligned bounding-box overlap test between box A and box B.
module box_overlap
    import collision_pkg::*;
#(
    parameter int A_WIDTH  = DEF_TANK_WIDTH,
    parameter int A_HEIGHT = DEF_TANK_HEIGHT,
    parameter int B_WIDTH  = DEF_BRICK_WIDTH,
    parameter int B_HEIGHT = DEF_BRICK_HEIGHT
) (
    input  logic [10:0] a_x,
    input  logic [10:0] a_y,
    input  logic [10:0] b_x,
    input  logic [10:0] b_y,
    output logic        overlap
);

    coord_t ax, ay, bx, by;

    // Touching edges count as overlap, hence <= / >= throughout.
    always_comb begin
        ax      = to_coord(a_x);
        ay      = to_coord(a_y);
        bx      = to_coord(b_x);
        by      = to_coord(b_y);
        overlap = (ax <= bx + coord_t'(B_WIDTH))  &&
                  (ax + coord_t'(A_WIDTH) >= bx)  &&
                  (ay <= by + coord_t'(B_HEIGHT)) &&
                  (ay + coord_t'(A_HEIGHT) >= by);
    end

endmodule

// File: rtl/collision_scheduler.sv
// Scans the brick table once per start request and reports the lowest-indexed brick overlapping the tank.
// Optional COLLISION_EARLY_EXIT_EN: finish the scan on the first hit instead of reading the whole table.
module collision_scheduler
    import collision_pkg::*;
#(
    parameter int NUM_BRICKS   = 16,
    parameter int BRICK_WIDTH  = DEF_BRICK_WIDTH,
    parameter int BRICK_HEIGHT = DEF_BRICK_HEIGHT,
    parameter int TANK_WIDTH   = DEF_TANK_WIDTH,
    parameter int TANK_HEIGHT  = DEF_TANK_HEIGHT,
    parameter int IDX_W        = (NUM_BRICKS > 1) ? $clog2(NUM_BRICKS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [10:0]      tankTopLeftX,
    input  logic [10:0]      tankTopLeftY,
    output logic             brick_rd_en,
    output logic [IDX_W-1:0] brick_addr,
    input  logic [10:0]      brickTopLeftX,
    input  logic [10:0]      brickTopLeftY,
    input  logic             brick_alive,
    output logic             busy,
    output logic             done,
    output logic             collision,
    output logic [IDX_W-1:0] hit_index
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BRICKS - 1);

    state_e           state_q, state_d;
    logic [10:0]      tank_x_q, tank_x_d, tank_y_q, tank_y_d;
    logic [IDX_W-1:0] addr_q, addr_d;
    logic             rd_en_q, rd_en_d;
    logic             vld_p1_q, vld_p1_d;
    logic [IDX_W-1:0] idx_p1_q, idx_p1_d;
    logic             scan_hit_q, scan_hit_d;
    logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
    logic             busy_q, busy_d, done_q, done_d, collision_q, collision_d;
    logic [IDX_W-1:0] hit_index_q, hit_index_d;

    logic             overlap, hit_now, hit_any;
    logic [IDX_W-1:0] hit_idx;

    box_overlap #(
        .A_WIDTH  (TANK_WIDTH),
        .A_HEIGHT (TANK_HEIGHT),
        .B_WIDTH  (BRICK_WIDTH),
        .B_HEIGHT (BRICK_HEIGHT)
    ) u_box_overlap (
        .a_x     (tank_x_q),
        .a_y     (tank_y_q),
        .b_x     (brickTopLeftX),
        .b_y     (brickTopLeftY),
        .overlap (overlap)
    );

    always_comb begin
        // Stage p1: table data returned for the address issued last cycle
        hit_now = vld_p1_q && brick_alive && overlap &&
                  ((state_q == SCAN) || (state_q == DRAIN));
        hit_any = scan_hit_q || hit_now;
        hit_idx = scan_hit_q ? scan_idx_q : idx_p1_q;

        state_d     = state_q;
        tank_x_d    = tank_x_q;
        tank_y_d    = tank_y_q;
        addr_d      = addr_q;
        rd_en_d     = rd_en_q;
        vld_p1_d    = rd_en_q;
        idx_p1_d    = addr_q;
        scan_hit_d  = hit_any;
        scan_idx_d  = hit_idx;
        busy_d      = busy_q;
        done_d      = 1'b0;
        collision_d = collision_q;
        hit_index_d = hit_index_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SCAN;
                    tank_x_d   = tankTopLeftX;
                    tank_y_d   = tankTopLeftY;
                    addr_d     = '0;
                    rd_en_d    = 1'b1;
                    scan_hit_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            SCAN: begin
                if (addr_q == LAST_IDX) begin
                    state_d = DRAIN;
                    rd_en_d = 1'b0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
`ifdef COLLISION_EARLY_EXIT_EN
                // Scan order is ascending, so the first hit is already the lowest index.
                if (hit_now) begin
                    state_d     = DONE;
                    rd_en_d     = 1'b0;
                    done_d      = 1'b1;
                    collision_d = 1'b1;
                    hit_index_d = hit_idx;
                end
`endif
            end
            DRAIN: begin
                state_d     = DONE;
                done_d      = 1'b1;
                collision_d = hit_any;
                hit_index_d = hit_any ? hit_idx : '0;
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        tank_x_q   <= tank_x_d;
        tank_y_q   <= tank_y_d;
        idx_p1_q   <= idx_p1_d;
        scan_idx_q <= scan_idx_d;
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rd_en_q     <= 1'b0;
            vld_p1_q    <= 1'b0;
            scan_hit_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            collision_q <= 1'b0;
            hit_index_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rd_en_q     <= rd_en_d;
            vld_p1_q    <= vld_p1_d;
            scan_hit_q  <= scan_hit_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            collision_q <= collision_d;
            hit_index_q <= hit_index_d;
        end
    end

    assign brick_rd_en = rd_en_q;
    assign brick_addr  = addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign collision   = collision_q;
    assign hit_index   = hit_index_q;

endmodule

// File: tb/tb_collision_scheduler.sv
// Directed bench for collision_scheduler with a cycle-level reference model of scan timing and results.
module tb_collision_scheduler;

    localparam int N   = 16;
    localparam int IW  = 4;
    localparam int DIM = 32;
`ifdef COLLISION_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [10:0]   tank_x = '0, tank_y = '0;
    logic          brick_rd_en;
    logic [IW-1:0] brick_addr;
    logic [10:0]   bx_q = '0, by_q = '0;
    logic          alive_q = 1'b0;
    logic          busy, done, collision;
    logic [IW-1:0] hit_index;

    int tbl_x [N];
    int tbl_y [N];
    bit tbl_alive [N];

    int n_pass = 0;
    int n_total = 0;
    int edge_cnt = 0;
    bit cmp_en = 1'b0;

    collision_scheduler #(.NUM_BRICKS(N)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .tankTopLeftX  (tank_x),
        .tankTopLeftY  (tank_y),
        .brick_rd_en   (brick_rd_en),
        .brick_addr    (brick_addr),
        .brickTopLeftX (bx_q),
        .brickTopLeftY (by_q),
        .brick_alive   (alive_q),
        .busy          (busy),
        .done          (done),
        .collision     (collision),
        .hit_index     (hit_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Brick table: one-cycle registered read.
    always @(posedge clk) begin
        if (brick_rd_en) begin
            bx_q    <= 11'(tbl_x[brick_addr]);
            by_q    <= 11'(tbl_y[brick_addr]);
            alive_q <= tbl_alive[brick_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Reference model: answer from the whole table, timing from scan length.
    function automatic int first_hit(input int tx, input int ty);
        int f;
        f = -1;
        for (int i = N - 1; i >= 0; i--)
            if (tbl_alive[i] && tx <= tbl_x[i] + DIM && tx + DIM >= tbl_x[i] &&
                ty <= tbl_y[i] + DIM && ty + DIM >= tbl_y[i])
                f = i;
        return f;
    endfunction

    function automatic int done_cycle(input int f);
        if (EARLY && f >= 0) return f + 3;
        return N + 2;
    endfunction

    function automatic int last_read(input int f);
        if (EARLY && f >= 0 && f + 2 < N) return f + 2;
        return N;
    endfunction

    bit m_active = 1'b0;
    int m_rel = 0, m_done_cyc = 0, m_last_rd = 0;
    bit m_new_coll = 1'b0, m_coll = 1'b0;
    int m_new_idx = 0, m_idx = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_active <= 1'b0;
            m_coll   <= 1'b0;
            m_idx    <= 0;
        end else if (m_active) begin
            if (m_rel == m_done_cyc) begin
                m_active <= 1'b0;
                m_coll   <= m_new_coll;
                m_idx    <= m_new_idx;
            end else begin
                m_rel <= m_rel + 1;
            end
        end else if (start) begin
            m_active   <= 1'b1;
            m_rel      <= 1;
            m_new_coll <= (first_hit(int'(tank_x), int'(tank_y)) >= 0);
            m_new_idx  <= (first_hit(int'(tank_x), int'(tank_y)) >= 0) ?
                          first_hit(int'(tank_x), int'(tank_y)) : 0;
            m_done_cyc <= done_cycle(first_hit(int'(tank_x), int'(tank_y)));
            m_last_rd  <= last_read(first_hit(int'(tank_x), int'(tank_y)));
        end
    end

    logic        exp_done, exp_rd, exp_coll;
    logic [31:0] exp_idx;
    assign exp_done = m_active && (m_rel == m_done_cyc);
    assign exp_rd   = m_active && (m_rel <= m_last_rd);
    assign exp_coll = exp_done ? m_new_coll : m_coll;
    assign exp_idx  = exp_done ? m_new_idx : m_idx;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", busy, exp_active_w());
            chk("done", done, exp_done);
            chk("rd_en", brick_rd_en, exp_rd);
            if (exp_rd) chk("addr", brick_addr, m_rel - 1);
            chk("collision", collision, exp_coll);
            chk("hit_index", hit_index, exp_idx);
        end
    end

    function automatic logic exp_active_w();
        return m_active;
    endfunction

    task automatic fill_far();
        for (int i = 0; i < N; i++) begin
            tbl_x[i] = 600;
            tbl_y[i] = 600;
            tbl_alive[i] = 1'b1;
        end
    endtask

    // Pulse start with the given tank position; returns with the bench in cycle 1.
    task automatic launch(input int tx, input int ty, output int e0);
        tank_x = 11'(tx);
        tank_y = 11'(ty);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        tank_x = '0;
        tank_y = '0;
        e0 = edge_cnt;
    endtask

    task automatic wait_done(input int e0, output int dc);
        dc = -1;
        for (int k = 0; k < 60; k++) begin
            if (done === 1'b1) begin
                dc = edge_cnt - e0 + 1;
                break;
            end
            @(negedge clk);
        end
        if (dc < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic run_scan(input string name, input int tx, input int ty,
                            input int exp_dc, input bit exp_c, input int exp_i);
        int e0, dc;
        launch(tx, ty, e0);
        wait_done(e0, dc);
        chk({name, "_done_cycle"}, dc, exp_dc);
        chk({name, "_collision"}, collision, exp_c);
        chk({name, "_hit_index"}, hit_index, exp_i);
        chk({name, "_model_idx"}, m_new_idx, exp_i);
        @(negedge clk);
    endtask

    initial begin
        int e0, dc, dones;
        fill_far();
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_collision", collision, 0);
        chk("reset_hit_index", hit_index, 0);
        chk("reset_rd_en", brick_rd_en, 0);
        chk("reset_addr", brick_addr, 0);
        reset  = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);

        fill_far();
        tbl_x[5] = 120; tbl_y[5] = 110;
        run_scan("t1", 100, 100, EARLY ? 8 : 18, 1'b1, 5);

        fill_far();
        tbl_x[3] = 132; tbl_y[3] = 100;
        tbl_x[9] = 100; tbl_y[9] = 132;
        run_scan("t2_edge", 100, 100, EARLY ? 6 : 18, 1'b1, 3);

        fill_far();
        tbl_x[2] = 110; tbl_y[2] = 110; tbl_alive[2] = 1'b0;
        run_scan("t3_dead", 100, 100, 18, 1'b0, 0);

        fill_far();
        tbl_x[0] = 0; tbl_y[0] = 0;
        run_scan("t4_nowrap", 2030, 2030, 18, 1'b0, 0);
        tbl_x[15] = 2047; tbl_y[15] = 2047;
        run_scan("t4_corner", 2030, 2030, 18, 1'b1, 15);

        // Reset mid-scan discards the scan and clears the held result.
        fill_far();
        tbl_x[5] = 120; tbl_y[5] = 110;
        launch(100, 100, e0);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_collision", collision, 0);
        chk("rst_hit_index", hit_index, 0);
        chk("rst_rd_en", brick_rd_en, 0);
        chk("rst_addr", brick_addr, 0);
        dones = 0;
        for (int k = 0; k < 25; k++) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        chk("rst_no_done", dones, 0);

        // Starts during the scan and during DONE are dropped; the one after DONE is taken.
        fill_far();
        launch(100, 100, e0);
        dones = 0;
        dc = -1;
        for (int c = 1; c <= 19; c++) begin
            if (done === 1'b1) begin
                dones++;
                dc = c;
            end
            start = (c == 4 || c == 18 || c == 19);
            @(negedge clk);
        end
        start = 1'b0;
        e0 = edge_cnt;
        chk("t5_single_done", dones, 1);
        chk("t5_done_cycle", dc, 18);
        chk("t5_restart_busy", busy, 1);
        wait_done(e0, dc);
        chk("t5_second_done_cycle", dc, 18);
        chk("t5_second_collision", collision, 0);
        @(negedge clk);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
